// File: rtl/bit_pkg.sv
// Shared types and helpers for the serial-to-word deserializer.
package bit_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Width of a counter that indexes 0..width-1; never narrower than one bit.
    function automatic int count_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/bit_shift_counter.sv
// WIDTH-bit serial shifter with a modulo-WIDTH bit counter and a wrap pulse.
module bit_shift_counter
    import bit_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        shift_en,
    input  logic                        din,
    output logic [WIDTH-1:0]            word,
    output logic [WIDTH-1:0]            shifted,
    output logic [count_w(WIDTH)-1:0]   count,
    output logic                        wrap
);

    localparam int CW = count_w(WIDTH);

    // shifted is the word as it will look after this cycle's bit, so a
    // completing word can be forwarded without waiting for the register.
    always_comb begin
        if (LSB_FIRST) begin
            shifted = {din, word[WIDTH-1:1]};
        end else begin
            shifted = {word[WIDTH-2:0], din};
        end
        wrap = shift_en && (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (shift_en) begin
            count <= wrap ? '0 : count + CW'(1);
        end
    end

    // Data path needs no reset: a word is only used once all WIDTH bits are in.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            word <= shifted;
        end
    end

endmodule

// File: rtl/bit_deserializer.sv
// Serial bit stream to WIDTH-bit words with a one-word output skid register.
module bit_deserializer
    import bit_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in0,
    input  logic                        in0_valid,
    output logic                        in0_ready,
    output logic [WIDTH-1:0]            out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [count_w(WIDTH)-1:0]   bit_count
);

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               out_free;
    logic               wrap;
    logic               load;
    logic [WIDTH-1:0]   word;
    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   load_word;

    assign accept   = in0_valid && in0_ready;
    assign out_free = !out_valid || out_ready;

    bit_shift_counter #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .din      (in0),
        .word     (word),
        .shifted  (shifted),
        .count    (bit_count),
        .wrap     (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FILL: if (wrap && !out_free) state_next = ST_HOLD;
            ST_HOLD: if (out_free)          state_next = ST_FILL;
            default:                        state_next = ST_FILL;
        endcase
    end

    // In FILL the completing word is still on the shifter input; in HOLD it
    // already sits in the shifter register.
    always_comb begin
        in0_ready = (state == ST_FILL) && !rst;
        load      = 1'b0;
        load_word = word;
        case (state)
            ST_FILL: begin
                load      = wrap && out_free;
                load_word = shifted;
            end
            ST_HOLD: begin
                load      = out_free;
                load_word = word;
            end
            default: begin
                load      = 1'b0;
                load_word = word;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out       <= load_word;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bit_deserializer.sv
// Scoreboard bench driving LSB-first and MSB-first instances with one shared stream.
module tb_bit_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in0;
    logic       in0_valid;
    logic       out_ready;

    logic       in0_ready_l, in0_ready_m;
    logic [7:0] out_l, out_m;
    logic       out_valid_l, out_valid_m;
    logic [2:0] bit_count_l, bit_count_m;

    int         checks = 0;
    int         errors = 0;
    int         cycle  = 0;
    int         stalls = 0;

    logic [7:0] q_l[$];
    logic [7:0] q_m[$];
    int         dcyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    bit_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .in0(in0), .in0_valid(in0_valid),
        .in0_ready(in0_ready_l), .out(out_l), .out_valid(out_valid_l),
        .out_ready(out_ready), .bit_count(bit_count_l)
    );

    bit_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .in0(in0), .in0_valid(in0_valid),
        .in0_ready(in0_ready_m), .out(out_m), .out_valid(out_valid_m),
        .out_ready(out_ready), .bit_count(bit_count_m)
    );

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    // Delivery monitor: every handshake must match the oldest expected word.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst && out_valid_l && out_ready) begin
            checks++;
            dcyc.push_back(cycle);
            if (q_l.size() == 0) begin
                errors++;
                $display("FAIL deliver_lsb: got unexpected word %h, none required", out_l);
            end else begin
                e = q_l.pop_front();
                if (out_l !== e) begin
                    errors++;
                    $display("FAIL deliver_lsb: got %h, required %h", out_l, e);
                end
            end
        end
        if (!rst && out_valid_m && out_ready) begin
            checks++;
            if (q_m.size() == 0) begin
                errors++;
                $display("FAIL deliver_msb: got unexpected word %h, none required", out_m);
            end else begin
                e = q_m.pop_front();
                if (out_m !== e) begin
                    errors++;
                    $display("FAIL deliver_msb: got %h, required %h", out_m, e);
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        int   tries;
        logic acc;
        in0       = b;
        in0_valid = 1'b1;
        tries     = 0;
        do begin
            @(negedge clk);
            acc = in0_ready_l;
            @(posedge clk);
            #1;
            tries++;
        end while (!acc && tries < 50);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in0_ready stayed %b, required 1", in0_ready_l);
        end
        if (tries > 1) stalls += tries - 1;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            send_bit(w[i]);
            checks++;
            if (bit_count_l !== 3'((i + 1) % 8) || bit_count_m !== 3'((i + 1) % 8)) begin
                errors++;
                $display("FAIL bit_count: got %0d/%0d, required %0d",
                         bit_count_l, bit_count_m, (i + 1) % 8);
            end
        end
        q_l.push_back(w);
        q_m.push_back(rev8(w));
        in0_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in0       = 1'b0;
        in0_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in0_ready_l !== 1'b0 || in0_ready_m !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_reset: got %b/%b, required 0", in0_ready_l, in0_ready_m);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_l !== 8'h00 || out_m !== 8'h00 || out_valid_l !== 1'b0 || out_valid_m !== 1'b0 ||
                bit_count_l !== 3'd0 || bit_count_m !== 3'd0 || in0_ready_l !== 1'b1 || in0_ready_m !== 1'b1) begin
                errors++;
                $display("FAIL idle: got out=%h/%h vld=%b/%b cnt=%0d/%0d rdy=%b/%b, required 00 0 0 1",
                         out_l, out_m, out_valid_l, out_valid_m, bit_count_l, bit_count_m,
                         in0_ready_l, in0_ready_m);
            end
        end
    endtask

    task automatic test_single_word();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send_word(8'h65);
        @(negedge clk);
        checks++;
        if (out_valid_l !== 1'b1 || out_l !== 8'h65 || out_valid_m !== 1'b1 || out_m !== 8'hA6) begin
            errors++;
            $display("FAIL single_word: got %b:%h / %b:%h, required 1:65 / 1:a6",
                     out_valid_l, out_l, out_valid_m, out_m);
        end
        @(negedge clk);
        checks++;
        if (out_valid_l !== 1'b0 || out_valid_m !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: out_valid got %b/%b, required 0", out_valid_l, out_valid_m);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        send_word(8'hFF);
        send_word(8'h0F);
        @(negedge clk);
        checks++;
        if (out_valid_l !== 1'b1 || out_l !== 8'hFF || in0_ready_l !== 1'b0 || in0_ready_m !== 1'b0) begin
            errors++;
            $display("FAIL hold_enter: got vld=%b out=%h rdy=%b/%b, required 1 ff 0",
                     out_valid_l, out_l, in0_ready_l, in0_ready_m);
        end
        in0       = 1'b1;
        in0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in0_ready_l !== 1'b0 || bit_count_l !== 3'd0 || out_l !== 8'hFF || out_m !== 8'hFF) begin
                errors++;
                $display("FAIL hold_stable: got rdy=%b cnt=%0d out=%h/%h, required 0 0 ff/ff",
                         in0_ready_l, bit_count_l, out_l, out_m);
            end
        end
        @(posedge clk);
        #1;
        in0_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid_l !== 1'b1 || out_l !== 8'h0F || out_m !== 8'hF0 || in0_ready_l !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got vld=%b out=%h/%h rdy=%b, required 1 0f/f0 1",
                     out_valid_l, out_l, out_m, in0_ready_l);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [4];
        words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hAA; words[3] = 8'h55;
        out_ready = 1'b1;
        dcyc.delete();
        stalls = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send_word(words[i]);
        repeat (3) @(negedge clk);
        checks++;
        if (stalls != 0 || dcyc.size() != 4) begin
            errors++;
            $display("FAIL stream: got %0d stalls %0d deliveries, required 0 stalls 4 deliveries",
                     stalls, dcyc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (dcyc[i] - dcyc[i-1] != 8) begin
                    errors++;
                    $display("FAIL stream_spacing: got %0d cycles, required 8", dcyc[i] - dcyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_word();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        in0_valid = 1'b0;
        checks++;
        if (bit_count_l !== 3'd5) begin
            errors++;
            $display("FAIL partial_count: got %0d, required 5", bit_count_l);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (bit_count_l !== 3'd0 || bit_count_m !== 3'd0 || out_valid_l !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got cnt=%0d/%0d vld=%b, required 0 0",
                     bit_count_l, bit_count_m, out_valid_l);
        end
        send_word(8'h3C);
        @(negedge clk);
        checks++;
        if (out_valid_l !== 1'b1 || out_l !== 8'h3C || out_m !== 8'h3C) begin
            errors++;
            $display("FAIL after_reset_word: got %b:%h/%h, required 1:3c/3c", out_valid_l, out_l, out_m);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        checks++;
        if (q_l.size() != 0 || q_m.size() != 0) begin
            errors++;
            $display("FAIL undelivered: got %0d/%0d words pending, required 0", q_l.size(), q_m.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
